// File: rtl/seq_alu_pkg.sv
// Shared types and helpers for the seq_alu registered ALU.
package seq_alu_pkg;

    // Opcode encoding presented on the op port.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOTA = 4'd7,
        OP_NOTB = 4'd8
    } op_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Highest legal opcode; anything above is flagged illegal.
    localparam logic [3:0] OP_LAST = 4'd8;

    // True when the request must go through the multi-cycle datapath.
    // A divide by zero is resolved immediately, and MUL is single-cycle
    // when the combinational multiplier is built in.
    function automatic logic is_iterative(input logic [3:0] op,
                                          input logic       b_zero,
                                          input logic       fast_mul);
        logic iter;
        iter = 1'b0;
        case (op)
            OP_MUL:  iter = ~fast_mul;
            OP_DIV:  iter = ~b_zero;
            default: iter = 1'b0;
        endcase
        return iter;
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Shared shift register / accumulator for shift-add multiply (mode=0)
// and restoring divide (mode=1). One step per cycle for WIDTH cycles;
// done pulses for one cycle after the last step.
module seq_alu_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod_quo,
    output logic [WIDTH-1:0]   rem
);

    localparam int CW = $clog2(WIDTH);

    // hi_r: MUL partial-product high half / DIV partial remainder.
    // lo_r: MUL multiplier shifting out / DIV dividend shifting into quotient.
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] opnd_r;
    logic [CW-1:0]    cnt_r;
    logic             run_r;
    logic             mode_r;
    logic             done_r;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_trial_s;
    logic [WIDTH:0]   div_diff_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] hi_nx_s;
    logic [WIDTH-1:0] lo_nx_s;

    // Next-state of the shared datapath for one multiply or divide step.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        div_trial_s = {hi_r, lo_r[WIDTH-1]};
        div_diff_s  = div_trial_s - {1'b0, opnd_r};
        div_ge_s    = (div_trial_s >= {1'b0, opnd_r});
        if (mode_r) begin
            hi_nx_s = div_ge_s ? div_diff_s[WIDTH-1:0] : div_trial_s[WIDTH-1:0];
            lo_nx_s = {lo_r[WIDTH-2:0], div_ge_s};
        end else begin
            hi_nx_s = mul_sum_s[WIDTH:1];
            lo_nx_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    // Operand load on start, then WIDTH steps counted down to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            opnd_r <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            run_r  <= 1'b0;
            mode_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= mode ? a : b;
            opnd_r <= mode ? b : a;
            cnt_r  <= CW'(WIDTH - 1);
            run_r  <= 1'b1;
            mode_r <= mode;
            done_r <= 1'b0;
        end else if (run_r) begin
            hi_r   <= hi_nx_s;
            lo_r   <= lo_nx_s;
            if (cnt_r == {CW{1'b0}}) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r - CW'(1);
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done     = done_r;
    assign prod_quo = mode_r ? {{WIDTH{1'b0}}, lo_r} : {hi_r, lo_r};
    assign rem      = mode_r ? hi_r : {WIDTH{1'b0}};

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready request port and held result port.
// Optional build macro SEQ_ALU_FAST_MUL_EN: MUL becomes a single-cycle
// combinational multiply; DIV remains iterative.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   remainder,
    output logic               carry,
    output logic               zero,
    output logic               div_by_zero,
    output logic               illegal_op
);

    localparam int RW = 2 * WIDTH;
`ifdef SEQ_ALU_FAST_MUL_EN
    localparam logic FAST_MUL = 1'b1;
`else
    localparam logic FAST_MUL = 1'b0;
`endif

    state_e           state_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [RW-1:0]    result_r;
    logic [WIDTH-1:0] remainder_r;
    logic             carry_r;
    logic             zero_r;
    logic             dbz_r;
    logic             illegal_r;

    logic             accept_s;
    logic             b_zero_s;
    logic             iter_s;
    logic             start_s;
    logic             mode_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] sc_lo_s;
    logic [WIDTH-1:0] sc_hi_s;
    logic [WIDTH-1:0] sc_rem_s;
    logic             sc_carry_s;
    logic             sc_dbz_s;
    logic             sc_ill_s;
    logic [RW-1:0]    sc_res_s;
    logic             iter_done_s;
    logic [RW-1:0]    iter_res_s;
    logic [WIDTH-1:0] iter_rem_s;

    assign accept_s = in_valid & in_ready_r;
    assign b_zero_s = (b == {WIDTH{1'b0}});
    assign iter_s   = is_iterative(op, b_zero_s, FAST_MUL);
    assign start_s  = accept_s & iter_s;
    assign mode_s   = (op == OP_DIV);
    assign add_s    = {1'b0, a} + {1'b0, b};
    assign sub_s    = {1'b0, a} - {1'b0, b};
    assign sc_res_s = {sc_hi_s, sc_lo_s};

    // Results of every op that completes in the accept cycle.
    always_comb begin
        sc_lo_s    = {WIDTH{1'b0}};
        sc_hi_s    = {WIDTH{1'b0}};
        sc_rem_s   = {WIDTH{1'b0}};
        sc_carry_s = 1'b0;
        sc_dbz_s   = 1'b0;
        sc_ill_s   = 1'b0;
        case (op)
            OP_ADD: begin
                sc_lo_s    = add_s[WIDTH-1:0];
                sc_hi_s    = {{(WIDTH-1){1'b0}}, add_s[WIDTH]};
                sc_carry_s = add_s[WIDTH];
            end
            OP_SUB: begin
                sc_lo_s    = sub_s[WIDTH-1:0];
                sc_carry_s = (a < b);
            end
            OP_MUL: begin
`ifdef SEQ_ALU_FAST_MUL_EN
                {sc_hi_s, sc_lo_s} = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`else
                sc_lo_s = {WIDTH{1'b0}};
`endif
            end
            OP_DIV: begin
                // Only consumed when b==0; a nonzero divisor goes iterative.
                sc_lo_s  = {WIDTH{1'b1}};
                sc_rem_s = a;
                sc_dbz_s = 1'b1;
            end
            OP_AND:  sc_lo_s = a & b;
            OP_OR:   sc_lo_s = a | b;
            OP_XOR:  sc_lo_s = a ^ b;
            OP_NOTA: sc_lo_s = ~a;
            OP_NOTB: sc_lo_s = ~b;
            default: sc_ill_s = (op > OP_LAST);
        endcase
    end

    seq_alu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_s),
        .mode     (mode_s),
        .a        (a),
        .b        (b),
        .done     (iter_done_s),
        .prod_quo (iter_res_s),
        .rem      (iter_rem_s)
    );

    // Controller: handshake, result/flag registers and state sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {RW{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            dbz_r       <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        in_ready_r <= 1'b0;
                        if (iter_s) begin
                            state_r   <= ST_BUSY;
                            carry_r   <= 1'b0;
                            zero_r    <= 1'b0;
                            dbz_r     <= 1'b0;
                            illegal_r <= 1'b0;
                        end else begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= sc_res_s;
                            remainder_r <= sc_rem_s;
                            carry_r     <= sc_carry_s;
                            zero_r      <= (sc_res_s == {RW{1'b0}});
                            dbz_r       <= sc_dbz_s;
                            illegal_r   <= sc_ill_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (iter_done_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= iter_res_s;
                        remainder_r <= iter_rem_s;
                        zero_r      <= (iter_res_s == {RW{1'b0}});
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign result      = result_r;
    assign remainder   = remainder_r;
    assign carry       = carry_r;
    assign zero        = zero_r;
    assign div_by_zero = dbz_r;
    assign illegal_op  = illegal_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus random requests
// compared against an arithmetic reference model.
module tb_seq_alu;

`ifdef SEQ_ALU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 9;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  op;
    logic [7:0]  a, b;
    logic [15:0] result;
    logic [7:0]  remainder;
    logic        carry, zero, div_by_zero, illegal_op;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  op4, a4, b4;
    logic [7:0]  result4;
    logic [3:0]  remainder4;
    logic        carry4, zero4, dbz4, ill4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .remainder(remainder), .carry(carry), .zero(zero),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    seq_alu #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .op(op4), .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .result(result4), .remainder(remainder4), .carry(carry4), .zero(zero4),
        .div_by_zero(dbz4), .illegal_op(ill4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model for WIDTH=8 in plain integer arithmetic.
    function automatic void model(input int o, input int ia, input int ib,
                                  output longint res, output longint rem,
                                  output bit cy, output bit dz, output bit il,
                                  output int lat);
        res = 0; rem = 0; cy = 0; dz = 0; il = 0; lat = 1;
        case (o)
            0: begin res = ia + ib; cy = (res > 255); end
            1: begin res = (ia - ib + 256) % 256; cy = (ia < ib); end
            2: begin res = ia * ib; lat = MUL_LAT; end
            3: begin
                if (ib == 0) begin res = 255; rem = ia; dz = 1; end
                else begin res = ia / ib; rem = ia % ib; lat = 9; end
            end
            4: res = ia & ib;
            5: res = ia | ib;
            6: res = ia ^ ib;
            7: res = 255 - ia;
            8: res = 255 - ib;
            default: il = 1;
        endcase
    endfunction

    // One request: issue, time the completion, check outputs, hold, release.
    task automatic run_op(input logic [3:0] o, input logic [7:0] ia, input logic [7:0] ib,
                          input int hold, input bit poke);
        longint er, erem;
        bit ecy, edz, eil;
        int elat, cycles;
        model(int'(o), int'(ia), int'(ib), er, erem, ecy, edz, eil, elat);
        chk("in_ready_before_issue", in_ready, 1);
        op = o; a = ia; b = ib; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cycles = 40;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                cycles = c;
                break;
            end
            chk("busy_in_ready", in_ready, 0);
            if (poke && c == 2) begin
                in_valid = 1'b1; op = 4'd0; a = 8'd1; b = 8'd1;
            end
            if (poke && c == 4) in_valid = 1'b0;
        end
        chk("latency", cycles, elat);
        chk("result", result, er);
        chk("remainder", remainder, erem);
        chk("carry", carry, ecy);
        chk("zero", zero, (er == 0));
        chk("div_by_zero", div_by_zero, edz);
        chk("illegal_op", illegal_op, eil);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_result", result, er);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        chk("idle_result_kept", result, er);
    endtask

    initial begin
        bit seen;
        logic [3:0] ro;
        logic [7:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; a = 8'd0; b = 8'd0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; op4 = 4'd0; a4 = 4'd0; b4 = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", {remainder, carry, zero, div_by_zero, illegal_op}, 0);
        rst_n = 1'b1;

        // WIDTH=4 ADD with carry-out
        in_valid4 = 1'b1; op4 = 4'd0; a4 = 4'd15; b4 = 4'd13;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        chk("w4_out_valid", out_valid4, 1);
        chk("w4_result", result4, 8'h1C);
        chk("w4_carry", carry4, 1);
        chk("w4_zero", zero4, 0);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        chk("w4_in_ready", in_ready4, 1);

        // Directed WIDTH=8 cases
        run_op(4'd1, 8'd3, 8'd5, 0, 1'b0);
        run_op(4'd1, 8'd5, 8'd5, 0, 1'b0);
        run_op(4'd2, 8'd255, 8'd255, 0, 1'b1);
        run_op(4'd2, 8'd0, 8'd77, 0, 1'b0);
        run_op(4'd3, 8'd200, 8'd7, 0, 1'b0);
        run_op(4'd3, 8'd42, 8'd0, 0, 1'b0);
        run_op(4'd12, 8'd9, 8'd9, 5, 1'b0);
        run_op(4'd7, 8'h0F, 8'h00, 1, 1'b0);
        run_op(4'd8, 8'h00, 8'hFF, 0, 1'b0);

        // Random requests
        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            run_op(ro, ra, rb, int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset during MUL: no completion afterwards
        op = 4'd2; a = 8'd11; b = 8'd13; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset_in_ready", in_ready, 1);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_result", result, 0);
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("no_late_completion", seen, 0);
        run_op(4'd6, 8'hA5, 8'h3C, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
